// File: rtl/seg_readback_decoder.sv
// Seven-segment bus snooper: qualifies each scanned digit and rebuilds BCD frames.
// Build option: define SEGDEC_ALT_GLYPH_EN to accept the alternate 7 (0x78) and 9 (0x18) glyphs.
module seg_readback_decoder #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   value_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic                  err_out,
    output logic                  frame_valid
);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYC - 1);
    localparam logic [7:0] CNT_SAT  = 8'(STABLE_CYC);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    logic [7:0]          seg_s1, seg_s2;
    logic [DIGITS-1:0]   an_s1, an_s2;
    logic [DIGITS+7:0]   prev_sample;
    state_t              state, state_nxt;
    logic [7:0]          cnt, cnt_nxt;
    logic [7:0]          zero_cnt;
    logic                one_cold, same, latch;
    logic [3:0]          glyph_nib;
    logic                glyph_err;
    logic [4*DIGITS-1:0] shadow_val, shadow_val_nxt;
    logic [DIGITS-1:0]   shadow_dp, shadow_dp_nxt;
    logic                shadow_err, shadow_err_nxt;
    logic [DIGITS-1:0]   mask, mask_nxt;
    logic                frame_done;

    // Two-flop synchronizers plus the previous synchronized sample for change detection
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1      <= '0;
            seg_s2      <= '0;
            an_s1       <= '0;
            an_s2       <= '0;
            prev_sample <= '0;
        end else begin
            seg_s1      <= seg_in;
            seg_s2      <= seg_s1;
            an_s1       <= an_in;
            an_s2       <= an_s1;
            prev_sample <= {an_s2, seg_s2};
        end
    end

    always_comb begin
        zero_cnt = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_s2[i]) zero_cnt = zero_cnt + 8'd1;
        end
        one_cold = (zero_cnt == 8'd1);
        same     = ({an_s2, seg_s2} == prev_sample);
    end

    always_comb begin
        glyph_nib = 4'hE;
        glyph_err = 1'b0;
        case (seg_s2[6:0])
            7'h40: glyph_nib = 4'h0;
            7'h79: glyph_nib = 4'h1;
            7'h24: glyph_nib = 4'h2;
            7'h30: glyph_nib = 4'h3;
            7'h19: glyph_nib = 4'h4;
            7'h12: glyph_nib = 4'h5;
            7'h02: glyph_nib = 4'h6;
            7'h58: glyph_nib = 4'h7;
            7'h00: glyph_nib = 4'h8;
            7'h10: glyph_nib = 4'h9;
            7'h7F: glyph_nib = 4'hF;
`ifdef SEGDEC_ALT_GLYPH_EN
            7'h78: glyph_nib = 4'h7;
            7'h18: glyph_nib = 4'h9;
`endif
            default: begin
                glyph_nib = 4'hE;
                glyph_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Dwell qualification: count saturates at STABLE_CYC once the digit is latched
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!one_cold) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SETTLE;
                    cnt_nxt   = 8'd1;
                end
                SETTLE: begin
                    if (!same) begin
                        cnt_nxt = 8'd1;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = HELD;
                        cnt_nxt   = CNT_SAT;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                HELD: begin
                    if (!same) begin
                        state_nxt = SETTLE;
                        cnt_nxt   = 8'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        latch = one_cold && (state == SETTLE) && same && (cnt == CNT_LAST);
    end

    // A full mask is transferred and cleared first, so a coincident latch opens the next frame
    always_comb begin
        frame_done     = &mask;
        mask_nxt       = frame_done ? '0 : mask;
        shadow_err_nxt = frame_done ? 1'b0 : shadow_err;
        shadow_val_nxt = shadow_val;
        shadow_dp_nxt  = shadow_dp;
        if (latch) begin
            shadow_err_nxt = shadow_err_nxt | glyph_err;
            for (int i = 0; i < DIGITS; i++) begin
                if (!an_s2[i]) begin
                    shadow_val_nxt[4*i +: 4] = glyph_nib;
                    shadow_dp_nxt[i]         = ~seg_s2[7];
                    mask_nxt[i]              = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask        <= '0;
            shadow_val  <= '0;
            shadow_dp   <= '0;
            shadow_err  <= 1'b0;
            value_out   <= '0;
            dp_out      <= '0;
            err_out     <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            mask        <= mask_nxt;
            shadow_val  <= shadow_val_nxt;
            shadow_dp   <= shadow_dp_nxt;
            shadow_err  <= shadow_err_nxt;
            frame_valid <= frame_done;
            if (frame_done) begin
                value_out <= shadow_val;
                dp_out    <= shadow_dp;
                err_out   <= shadow_err;
            end
        end
    end

endmodule

// File: tb/tb_seg_readback_decoder.sv
// Self-checking bench for seg_readback_decoder: glyph table, directed scans and a random scan
// compared every cycle against a run-length reference model.
module tb_seg_readback_decoder;
    localparam int DIGITS     = 4;
    localparam int STABLE_CYC = 4;

    localparam logic [6:0] GLYPHS [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h58, 7'h00, 7'h10};
`ifdef SEGDEC_ALT_GLYPH_EN
    localparam logic       ALT_ON = 1'b1;
`else
    localparam logic       ALT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  seg_in = 8'hFF;
    logic [3:0]  an_in = 4'hF;
    logic [15:0] value_out;
    logic [3:0]  dp_out;
    logic        err_out;
    logic        frame_valid;

    seg_readback_decoder #(.DIGITS(DIGITS), .STABLE_CYC(STABLE_CYC)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
        .value_out(value_out), .dp_out(dp_out), .err_out(err_out), .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int pulses   = 0;
    logic [15:0] cap_val;
    logic [3:0]  cap_dp;
    logic        cap_err;

    // Reference model: pins delayed two edges, run length of identical samples
    logic [11:0] m_s1, m_s2, m_prev;
    int          m_run;
    logic [3:0]  m_mask;
    logic [3:0]  m_nib [4];
    logic [3:0]  m_dp;
    logic        m_err;
    logic [15:0] e_val;
    logic [3:0]  e_dp;
    logic        e_err, e_fv;

    typedef struct {
        logic [7:0] seg;
        logic [3:0] nib;
        logic       dp;
        logic       err;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [4:0] refDecode(input logic [6:0] g);
        if (g == 7'h7F) return {1'b0, 4'hF};
        for (int k = 0; k < 10; k++) begin
            if (GLYPHS[k] == g) return {1'b0, 4'(k)};
        end
        if (ALT_ON && g == 7'h78) return {1'b0, 4'h7};
        if (ALT_ON && g == 7'h18) return {1'b0, 4'h9};
        return {1'b1, 4'hE};
    endfunction

    task automatic modelStep();
        logic [4:0] d;
        logic [3:0] an2;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_prev = '0; m_run = 0;
            m_mask = '0; m_dp = '0; m_err = 1'b0;
            for (int k = 0; k < 4; k++) m_nib[k] = '0;
            e_val = '0; e_dp = '0; e_err = 1'b0; e_fv = 1'b0;
        end else begin
            an2   = m_s2[11:8];
            m_run = (m_s2 == m_prev) ? m_run + 1 : 1;
            e_fv  = 1'b0;
            if (m_mask == 4'hF) begin
                e_val  = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                e_dp   = m_dp;
                e_err  = m_err;
                e_fv   = 1'b1;
                m_mask = '0;
                m_err  = 1'b0;
            end
            if (m_run == STABLE_CYC && $countones(~an2) == 1) begin
                d = refDecode(m_s2[6:0]);
                for (int k = 0; k < 4; k++) begin
                    if (!an2[k]) begin
                        m_nib[k]  = d[3:0];
                        m_dp[k]   = ~m_s2[7];
                        m_mask[k] = 1'b1;
                    end
                end
                m_err = m_err | d[4];
            end
            m_prev = m_s2;
            m_s2   = m_s1;
            m_s1   = {an_in, seg_in};
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        n_checks++;
        if ({frame_valid, value_out, dp_out, err_out} !== {e_fv, e_val, e_dp, e_err}) begin
            n_fail++;
            $display("[TB] FAIL cycle %0d: got fv=%b val=%h dp=%b err=%b, expected fv=%b val=%h dp=%b err=%b",
                     cycle, frame_valid, value_out, dp_out, err_out, e_fv, e_val, e_dp, e_err);
        end
        if (frame_valid === 1'b1) begin
            pulses++;
            cap_val = value_out;
            cap_dp  = dp_out;
            cap_err = err_out;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [7:0] s, input int n);
        for (int c = 0; c < n; c++) begin
            an_in  = a;
            seg_in = s;
            @(posedge clk);
            modelStep();
            #1;
            cycle++;
            checkOutput();
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(4'hF, 8'hFF, 1);
        rst = 1'b0;
    endtask

    task automatic scanFrame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                             input logic [7:0] s3, input int dwell);
        applyStimulus(4'b1110, s0, dwell);
        applyStimulus(4'b1101, s1, dwell);
        applyStimulus(4'b1011, s2, dwell);
        applyStimulus(4'b0111, s3, dwell);
    endtask

    initial begin
        logic [3:0] ra;
        logic [7:0] rs;
        int         pick;

        vecs.push_back('{8'hC0, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{8'h79, 4'h1, 1'b1, 1'b0});
        vecs.push_back('{8'hA4, 4'h2, 1'b0, 1'b0});
        vecs.push_back('{8'h30, 4'h3, 1'b1, 1'b0});
        vecs.push_back('{8'h99, 4'h4, 1'b0, 1'b0});
        vecs.push_back('{8'h92, 4'h5, 1'b0, 1'b0});
        vecs.push_back('{8'h02, 4'h6, 1'b1, 1'b0});
        vecs.push_back('{8'hD8, 4'h7, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 4'h8, 1'b0, 1'b0});
        vecs.push_back('{8'h10, 4'h9, 1'b1, 1'b0});
        vecs.push_back('{8'hFF, 4'hF, 1'b0, 1'b0});
        vecs.push_back('{8'h7F, 4'hF, 1'b1, 1'b0});
        vecs.push_back('{8'hFE, 4'hE, 1'b0, 1'b1});
        vecs.push_back('{8'h88, 4'hE, 1'b0, 1'b1});
        vecs.push_back('{8'hF8, ALT_ON ? 4'h7 : 4'hE, 1'b0, ~ALT_ON});
        vecs.push_back('{8'h18, ALT_ON ? 4'h9 : 4'hE, 1'b1, ~ALT_ON});

        doReset();
        checkValue("reset value", 32'(value_out), 32'h0);
        checkValue("reset dp/err/fv", {28'h0, dp_out, err_out, frame_valid}, 32'h0);

        $display("[TB] glyph table");
        for (int v = 0; v < vecs.size(); v++) begin
            pulses = 0;
            scanFrame(vecs[v].seg, 8'hA4, 8'hB0, 8'h99, 6);
            applyStimulus(4'hF, 8'hFF, 6);
            checkValue($sformatf("table %0d pulses", v), 32'(pulses), 32'd1);
            checkValue($sformatf("table %0d value", v), 32'(cap_val), {16'h0, 12'h432, vecs[v].nib});
            checkValue($sformatf("table %0d dp", v), 32'(cap_dp), {31'h0, vecs[v].dp});
            checkValue($sformatf("table %0d err", v), 32'(cap_err), {31'h0, vecs[v].err});
        end

        $display("[TB] normal frame");
        doReset(); pulses = 0;
        scanFrame(8'hF9, 8'hA4, 8'hB0, 8'h99, 8);
        applyStimulus(4'hF, 8'hFF, 8);
        checkValue("normal pulses", 32'(pulses), 32'd1);
        checkValue("normal value", 32'(cap_val), 32'h4321);
        checkValue("normal dp/err", {27'h0, cap_dp, cap_err}, 32'h0);

        $display("[TB] dot, short dwell and retry");
        doReset(); pulses = 0;
        applyStimulus(4'b1110, 8'h40, 8);
        applyStimulus(4'b1101, 8'hA4, 8);
        applyStimulus(4'b1011, 8'hB0, STABLE_CYC - 1);
        applyStimulus(4'b0111, 8'h99, 8);
        applyStimulus(4'hF, 8'hFF, 8);
        checkValue("short dwell pulses", 32'(pulses), 32'd0);
        scanFrame(8'h40, 8'hA4, 8'hB0, 8'h99, 8);
        applyStimulus(4'hF, 8'hFF, 8);
        checkValue("retry pulses", 32'(pulses), 32'd1);
        checkValue("retry value", 32'(cap_val), 32'h4320);
        checkValue("retry dp", 32'(cap_dp), 32'h1);

        $display("[TB] invalid glyph and blank");
        doReset(); pulses = 0;
        scanFrame(8'hC0, 8'hFE, 8'hB0, 8'hFF, 8);
        applyStimulus(4'hF, 8'hFF, 8);
        checkValue("invalid value", 32'(cap_val), 32'hF3E0);
        checkValue("invalid err", 32'(cap_err), 32'h1);
        scanFrame(8'hF9, 8'hA4, 8'hB0, 8'h99, 8);
        applyStimulus(4'hF, 8'hFF, 8);
        checkValue("clean pulses", 32'(pulses), 32'd2);
        checkValue("clean err", 32'(cap_err), 32'h0);

        $display("[TB] illegal anode");
        doReset(); pulses = 0;
        applyStimulus(4'b1110, 8'hF9, 8);
        applyStimulus(4'b1101, 8'hA4, 8);
        applyStimulus(4'b1100, 8'hB0, 20);
        checkValue("illegal no pulse", 32'(pulses), 32'd0);
        applyStimulus(4'b1011, 8'hB0, 8);
        applyStimulus(4'b0111, 8'h99, 8);
        applyStimulus(4'hF, 8'hFF, 8);
        checkValue("illegal pulses", 32'(pulses), 32'd1);
        checkValue("illegal value", 32'(cap_val), 32'h4321);

        $display("[TB] reset mid-frame");
        doReset();
        scanFrame(8'hF9, 8'hA4, 8'hB0, 8'h99, 8);
        applyStimulus(4'hF, 8'hFF, 4);
        applyStimulus(4'b1110, 8'hC0, 8);
        applyStimulus(4'b1101, 8'hA4, 8);
        rst = 1'b1;
        applyStimulus(4'b1011, 8'hB0, 1);
        rst = 1'b0;
        checkValue("midreset value", 32'(value_out), 32'h0);
        checkValue("midreset dp/err/fv", {28'h0, dp_out, err_out, frame_valid}, 32'h0);
        pulses = 0;
        applyStimulus(4'b1011, 8'hB0, 8);
        applyStimulus(4'b0111, 8'h99, 8);
        applyStimulus(4'hF, 8'hFF, 8);
        checkValue("partial discarded", 32'(pulses), 32'd0);
        applyStimulus(4'b1110, 8'hC0, 8);
        applyStimulus(4'b1101, 8'hA4, 8);
        applyStimulus(4'hF, 8'hFF, 8);
        checkValue("post-reset pulses", 32'(pulses), 32'd1);
        checkValue("post-reset value", 32'(cap_val), 32'h4320);

        $display("[TB] configuration glyph");
        doReset(); pulses = 0;
        scanFrame(8'hF8, 8'hA4, 8'hB0, 8'h99, 8);
        applyStimulus(4'hF, 8'hFF, 8);
        checkValue("alt7 value", 32'(cap_val), ALT_ON ? 32'h4327 : 32'h432E);
        checkValue("alt7 err", 32'(cap_err), ALT_ON ? 32'h0 : 32'h1);

        $display("[TB] random scan");
        doReset();
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0) ra = 4'($urandom_range(0, 15));
            else           ra = ~(4'b0001 << $urandom_range(0, 3));
            pick = $urandom_range(0, 9);
            if (pick < 7) begin
                rs = {1'($urandom_range(0, 1)), GLYPHS[$urandom_range(0, 9)]};
            end else if (pick == 7) begin
                rs = 8'hFF;
            end else begin
                rs = 8'($urandom_range(0, 255));
            end
            applyStimulus(ra, rs, $urandom_range(2, 8));
            if ($urandom_range(0, 99) == 0) doReset();
        end
        applyStimulus(4'hF, 8'hFF, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
